// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, X-stage flushes and
// multicycle mult/div sequencing. It drives latch enables and nop selects only.
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      dx_ir,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             pc_we,
  output logic             fd_we,
  output logic             dx_we,
  output logic             fd_nop,
  output logic             dx_nop,
  output logic             xm_nop,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned TMR_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam int unsigned REG_W = 5;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {ST_RUN, ST_MD_WAIT} state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               md_error_q, md_error_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  logic [REG_W-1:0]   fd_src_a, fd_src_b;
  logic [REG_W-1:0]   dx_rd;
  logic               dx_is_lw, dx_is_md, load_use, timer_expired;
  logic               unused_ir_bits;

  assign unused_ir_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  // Register sources read by the F/D instruction; register 0 doubles as "none".
  always_comb begin
    fd_src_a = '0;
    fd_src_b = '0;
    case (fd_ir[31:27])
      OP_RTYPE: begin
        fd_src_a = fd_ir[21:17];
        fd_src_b = fd_ir[16:12];
      end
      OP_ADDI, OP_LW: fd_src_a = fd_ir[21:17];
      OP_SW, OP_BNE, OP_BLT: begin
        fd_src_a = fd_ir[26:22];
        fd_src_b = fd_ir[21:17];
      end
      OP_JR: fd_src_a = fd_ir[26:22];
      default: ;
    endcase
  end

  assign dx_rd         = dx_ir[26:22];
  assign dx_is_lw      = (dx_ir[31:27] == OP_LW);
  assign dx_is_md      = (dx_ir[31:27] == OP_RTYPE) &&
                         ((dx_ir[6:2] == ALU_MUL) || (dx_ir[6:2] == ALU_DIV));
  assign load_use      = dx_is_lw && (dx_rd != '0) &&
                         ((dx_rd == fd_src_a) || (dx_rd == fd_src_b));
  assign timer_expired = (timer_q == TMR_W'(MD_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (dx_is_md) state_d = ST_MD_WAIT;
      ST_MD_WAIT: if (md_ready || timer_expired) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // Mul/div in D/X outranks flush; a branch cannot resolve while X holds a mul/div.
  always_comb begin
    pc_we    = 1'b1;
    fd_we    = 1'b1;
    dx_we    = 1'b1;
    fd_nop   = 1'b0;
    dx_nop   = 1'b0;
    xm_nop   = 1'b0;
    md_start = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dx_is_md) begin
          md_start = 1'b1;
          pc_we    = 1'b0;
          fd_we    = 1'b0;
          dx_we    = 1'b0;
          xm_nop   = 1'b1;
        end else if (branch_taken) begin
          fd_nop = 1'b1;
          dx_nop = 1'b1;
        end else if (load_use) begin
          pc_we  = 1'b0;
          fd_we  = 1'b0;
          dx_nop = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        if (!md_ready) begin
          xm_nop = 1'b1;
          if (!timer_expired) begin
            pc_we = 1'b0;
            fd_we = 1'b0;
            dx_we = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    timer_d       = '0;
    md_error_d    = md_error_q;
    stall_count_d = stall_count_q;
    if (state_q == ST_MD_WAIT && !md_ready) begin
      if (timer_expired) md_error_d = 1'b1;
      else               timer_d    = timer_q + TMR_W'(1);
    end
    if (!pc_we && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q       <= '0;
      md_error_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      timer_q       <= timer_d;
      md_error_q    <= md_error_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign md_busy     = (state_q == ST_MD_WAIT);
  assign md_error    = md_error_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO      = 8;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = 15;

  logic          clock;
  logic          reset;
  logic [31:0]   fd_ir, dx_ir;
  logic          branch_taken, md_ready;
  logic          pc_we, fd_we, dx_we, fd_nop, dx_nop, xm_nop;
  logic          md_start, md_busy, md_error;
  logic [CW-1:0] stall_count;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we),
    .fd_nop(fd_nop), .dx_nop(dx_nop), .xm_nop(xm_nop),
    .md_start(md_start), .md_busy(md_busy), .md_error(md_error),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit pc, fd, dx, fn, dn, xn, st, busy, err;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: are we waiting on mult/div, how long, sticky error, stall total.
  bit   m_wait  = 0;
  int   m_waits = 0;
  bit   m_err   = 0;
  int   m_cnt   = 0;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                     input int rt, input int alu);
    return {5'(op), 5'(rd), 5'(rs), 5'(rt), 5'b0, 5'(alu), 2'b0};
  endfunction

  function automatic bit is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
  endfunction

  function automatic bit reads_reg(input logic [31:0] ir, input int r);
    int op = int'(ir[31:27]);
    int rd = int'(ir[26:22]);
    int rs = int'(ir[21:17]);
    int rt = int'(ir[16:12]);
    case (op)
      0:       return (rs == r) || (rt == r);
      5, 8:    return rs == r;
      2, 6, 7: return (rd == r) || (rs == r);
      4:       return rd == r;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_ir();
    logic [31:0] ir = $urandom;
    int k = $urandom_range(0, 13);
    int op;
    case (k)
      0, 1, 2, 3: op = 0;
      4:          op = 1;
      5:          op = 2;
      6:          op = 3;
      7:          op = 4;
      8:          op = 5;
      9:          op = 6;
      10:         op = 7;
      11, 12:     op = 8;
      default:    op = 21;
    endcase
    ir[31:27] = 5'(op);
    ir[26:22] = 5'($urandom_range(0, 3));
    ir[21:17] = 5'($urandom_range(0, 3));
    ir[16:12] = 5'($urandom_range(0, 3));
    if (op == 0) ir[6:2] = 5'($urandom_range(0, 7));
    return ir;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, want);
    end
  endtask

  // Drive one cycle of inputs, predict the DUT response and queue it.
  task automatic step(input logic [31:0] f, input logic [31:0] d,
                      input bit b, input bit r, input bit rs);
    exp_t e;
    bit   n_wait;
    int   n_waits;
    bit   n_err;
    @(posedge clock);
    #1;
    fd_ir = f; dx_ir = d; branch_taken = b; md_ready = r; reset = rs;
    if (rs) begin
      m_wait = 0; m_waits = 0; m_err = 0; m_cnt = 0;
    end
    e.pc = 1; e.fd = 1; e.dx = 1; e.fn = 0; e.dn = 0; e.xn = 0; e.st = 0;
    e.busy = m_wait; e.err = m_err; e.cnt = m_cnt;
    n_wait = m_wait; n_waits = m_waits; n_err = m_err;
    if (!m_wait) begin
      if (is_md(d)) begin
        e.st = 1; e.pc = 0; e.fd = 0; e.dx = 0; e.xn = 1;
        n_wait = 1; n_waits = 0;
      end else if (b) begin
        e.fn = 1; e.dn = 1;
      end else if (d[31:27] == 5'd8 && d[26:22] != 5'd0 && reads_reg(f, int'(d[26:22]))) begin
        e.pc = 0; e.fd = 0; e.dn = 1;
      end
    end else if (r) begin
      n_wait = 0;
    end else if (m_waits == TO - 1) begin
      e.xn = 1; n_err = 1; n_wait = 0;
    end else begin
      e.pc = 0; e.fd = 0; e.dx = 0; e.xn = 1; n_waits = m_waits + 1;
    end
    sb.push_back(e);
    if (!rs) begin
      m_wait = n_wait; m_waits = n_wait ? n_waits : 0; m_err = n_err;
      if (!e.pc && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_we",       32'(pc_we),       32'(e.pc));
        chk("fd_we",       32'(fd_we),       32'(e.fd));
        chk("dx_we",       32'(dx_we),       32'(e.dx));
        chk("fd_nop",      32'(fd_nop),      32'(e.fn));
        chk("dx_nop",      32'(dx_nop),      32'(e.dn));
        chk("xm_nop",      32'(xm_nop),      32'(e.xn));
        chk("md_start",    32'(md_start),    32'(e.st));
        chk("md_busy",     32'(md_busy),     32'(e.busy));
        chk("md_error",    32'(md_error),    32'(e.err));
        chk("stall_count", 32'(stall_count), 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    logic [31:0] lw_r3, add_r4, mul_op, div_op;
    reset = 1'b1; fd_ir = '0; dx_ir = '0; branch_taken = 1'b0; md_ready = 1'b0;
    lw_r3  = mk(8, 3, 1, 0, 0);
    add_r4 = mk(0, 4, 3, 2, 0);
    mul_op = mk(0, 1, 2, 3, 6);
    div_op = mk(0, 2, 3, 4, 7);

    step('0, '0, 0, 0, 1);
    step('0, '0, 0, 0, 1);
    // Load-use stall and its bubble.
    step(add_r4, lw_r3, 0, 0, 0);
    step(add_r4, '0, 0, 0, 0);
    // Register 0 and non-reading consumers never stall; sw/jr read rd.
    step(mk(0, 4, 0, 2, 0), mk(8, 0, 1, 0, 0), 0, 0, 0);
    step(mk(5, 5, 6, 0, 0) | 32'd1, lw_r3, 0, 0, 0);
    step(mk(7, 3, 1, 0, 0), lw_r3, 0, 0, 0);
    step(mk(4, 3, 0, 0, 0), lw_r3, 0, 0, 0);
    // Flush wins over load-use.
    step(add_r4, lw_r3, 1, 0, 0);
    // Mul with ready after three wait cycles; branch ignored while waiting.
    step('0, mul_op, 0, 0, 0);
    step('0, mul_op, 0, 0, 0);
    step('0, mul_op, 1, 0, 0);
    step('0, mul_op, 0, 0, 0);
    step(add_r4, mul_op, 0, 1, 0);
    // Back-to-back div with immediate ready.
    step('0, div_op, 0, 0, 0);
    step('0, '0, 0, 1, 0);
    // Timeout: ready never arrives.
    step('0, div_op, 0, 0, 0);
    repeat (TO) step('0, '0, 0, 0, 0);
    step('0, '0, 0, 0, 0);
    // Reset in the middle of a wait.
    step('0, mul_op, 0, 0, 0);
    step('0, mul_op, 0, 0, 0);
    step('0, mul_op, 0, 0, 0);
    step('0, mul_op, 0, 0, 1);
    step('0, '0, 0, 0, 0);
    step(add_r4, lw_r3, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] f, d;
      bit b, r, rs;
      f  = rnd_ir();
      d  = rnd_ir();
      r  = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      b  = ($urandom_range(0, 4) == 0) && !is_md(d);
      rs = ($urandom_range(0, 199) == 0);
      step(f, d, b, r, rs);
    end

    @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
